// File: rtl/comparator_if.sv
// Operand/result bundle for the registered magnitude comparator.
// Valid semantics: in_valid qualifies in1/in2 on each rising edge. out_valid follows it one
// cycle later. There is no backpressure, so every valid sample is consumed on its edge.
interface comparator_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cnt_clr;
    logic             lesser;
    logic             equal;
    logic             greater;
    logic             out_valid;
    logic [CNT_W-1:0] cnt_lt;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_gt;

    modport master (
        output in_valid, in1, in2, cnt_clr,
        input  lesser, equal, greater, out_valid, cnt_lt, cnt_eq, cnt_gt
    );

    modport slave (
        input  in_valid, in1, in2, cnt_clr,
        output lesser, equal, greater, out_valid, cnt_lt, cnt_eq, cnt_gt
    );
endinterface

// File: rtl/comparator.sv
// Registered magnitude comparator with one-hot lt/eq/gt flags, a valid qualifier,
// and saturating per-outcome event counters.
module comparator #(
    parameter int WIDTH      = 3,
    parameter int SIGNED_CMP = 0,
    parameter int CNT_W      = 8
) (
    input logic          clk,
    input logic          rst_n,
    comparator_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             lt_c;
    logic             eq_c;
    logic             gt_c;
    logic             lesser_q;
    logic             equal_q;
    logic             greater_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_lt_q;
    logic [CNT_W-1:0] cnt_eq_q;
    logic [CNT_W-1:0] cnt_gt_q;

    always_comb begin
        lt_c = 1'b0;
        if (SIGNED_CMP != 0) begin
            lt_c = $signed(bus.in1) < $signed(bus.in2);
        end else begin
            lt_c = bus.in1 < bus.in2;
        end
        eq_c = bus.in1 == bus.in2;
        gt_c = !lt_c && !eq_c;
    end

    // Flags hold their last result while in_valid is low; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                lesser_q  <= lt_c;
                equal_q   <= eq_c;
                greater_q <= gt_c;
            end
        end
    end

    // A clear wins over a same-edge increment, so that sample goes uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lt_q <= '0;
            cnt_eq_q <= '0;
            cnt_gt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_lt_q <= '0;
            cnt_eq_q <= '0;
            cnt_gt_q <= '0;
        end else if (bus.in_valid) begin
            if (lt_c && cnt_lt_q != CNT_MAX) cnt_lt_q <= cnt_lt_q + CNT_ONE;
            if (eq_c && cnt_eq_q != CNT_MAX) cnt_eq_q <= cnt_eq_q + CNT_ONE;
            if (gt_c && cnt_gt_q != CNT_MAX) cnt_gt_q <= cnt_gt_q + CNT_ONE;
        end
    end

    assign bus.lesser    = lesser_q;
    assign bus.equal     = equal_q;
    assign bus.greater   = greater_q;
    assign bus.out_valid = valid_q;
    assign bus.cnt_lt    = cnt_lt_q;
    assign bus.cnt_eq    = cnt_eq_q;
    assign bus.cnt_gt    = cnt_gt_q;
endmodule

// File: tb/tb_comparator.sv
// Bench for comparator: unsigned, signed and narrow-counter builds share one stimulus stream
// and are checked every cycle against an arithmetic model.
module tb_comparator;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    int checks = 0;
    int errors = 0;

    // index 0: unsigned CNT_W=8, 1: signed CNT_W=8, 2: unsigned CNT_W=2
    int sgn[3] = '{0, 1, 0};
    int cmax[3] = '{255, 255, 3};
    int e_flag[3][3];
    int e_cnt[3][3];
    int e_ov[3];

    comparator_if #(.WIDTH(W), .CNT_W(8)) iu ();
    comparator_if #(.WIDTH(W), .CNT_W(8)) i_s ();
    comparator_if #(.WIDTH(W), .CNT_W(2)) ic ();

    comparator #(.WIDTH(W), .SIGNED_CMP(0), .CNT_W(8)) dut_u (.clk(clk), .rst_n(rst_n), .bus(iu.slave));
    comparator #(.WIDTH(W), .SIGNED_CMP(1), .CNT_W(8)) dut_s (.clk(clk), .rst_n(rst_n), .bus(i_s.slave));
    comparator #(.WIDTH(W), .SIGNED_CMP(0), .CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 3; k++) begin
            e_ov[k] = 0;
            for (int j = 0; j < 3; j++) begin
                e_flag[k][j] = 0;
                e_cnt[k][j] = 0;
            end
        end
    end

    // 0 = lesser, 1 = equal, 2 = greater
    function automatic int outcome(input int a, input int b, input int s);
        int x;
        int y;
        x = a;
        y = b;
        if (s != 0) begin
            if (x >= (1 << (W - 1))) x = x - (1 << W);
            if (y >= (1 << (W - 1))) y = y - (1 << W);
        end
        if (x < y) return 0;
        if (x == y) return 1;
        return 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                e_ov[k] = 0;
                for (int j = 0; j < 3; j++) begin
                    e_flag[k][j] = 0;
                    e_cnt[k][j] = 0;
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int o;
                o = outcome(int'(iu.in1), int'(iu.in2), sgn[k]);
                e_ov[k] = iu.in_valid ? 1 : 0;
                if (iu.in_valid) begin
                    for (int j = 0; j < 3; j++) e_flag[k][j] = (j == o) ? 1 : 0;
                end
                if (iu.cnt_clr) begin
                    for (int j = 0; j < 3; j++) e_cnt[k][j] = 0;
                end else if (iu.in_valid && e_cnt[k][o] < cmax[k]) begin
                    e_cnt[k][o] = e_cnt[k][o] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input int k, input string tag, input int l, input int e, input int g,
                           input int ov, input int clt, input int ceq, input int cgt);
        chk({tag, ".lesser"}, l, e_flag[k][0]);
        chk({tag, ".equal"}, e, e_flag[k][1]);
        chk({tag, ".greater"}, g, e_flag[k][2]);
        chk({tag, ".out_valid"}, ov, e_ov[k]);
        chk({tag, ".cnt_lt"}, clt, e_cnt[k][0]);
        chk({tag, ".cnt_eq"}, ceq, e_cnt[k][1]);
        chk({tag, ".cnt_gt"}, cgt, e_cnt[k][2]);
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk_dut(0, "u", int'(iu.lesser), int'(iu.equal), int'(iu.greater), int'(iu.out_valid),
                    int'(iu.cnt_lt), int'(iu.cnt_eq), int'(iu.cnt_gt));
            chk_dut(1, "s", int'(i_s.lesser), int'(i_s.equal), int'(i_s.greater), int'(i_s.out_valid),
                    int'(i_s.cnt_lt), int'(i_s.cnt_eq), int'(i_s.cnt_gt));
            chk_dut(2, "c", int'(ic.lesser), int'(ic.equal), int'(ic.greater), int'(ic.out_valid),
                    int'(ic.cnt_lt), int'(ic.cnt_eq), int'(ic.cnt_gt));
        end
    end

    task automatic drive(input int a, input int b, input bit v, input bit clr);
        iu.in1 = W'(a);   iu.in2 = W'(b);   iu.in_valid = v;   iu.cnt_clr = clr;
        i_s.in1 = W'(a);  i_s.in2 = W'(b);  i_s.in_valid = v;  i_s.cnt_clr = clr;
        ic.in1 = W'(a);   ic.in2 = W'(b);   ic.in_valid = v;   ic.cnt_clr = clr;
    endtask

    // Inputs change on the falling edge; returns 1 time unit after the next rising edge.
    task automatic step(input int a, input int b, input bit v, input bit clr);
        @(negedge clk);
        drive(a, b, v, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".u_flags"}, int'({iu.lesser, iu.equal, iu.greater, iu.out_valid}), 0);
        chk({tag, ".u_cnts"}, int'(iu.cnt_lt) + int'(iu.cnt_eq) + int'(iu.cnt_gt), 0);
        chk({tag, ".s_flags"}, int'({i_s.lesser, i_s.equal, i_s.greater, i_s.out_valid}), 0);
        chk({tag, ".c_cnts"}, int'(ic.cnt_lt) + int'(ic.cnt_eq) + int'(ic.cnt_gt), 0);
    endtask

    initial begin
        drive(0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;

        step(2, 5, 1'b1, 1'b0);
        chk("lit_2v5_lesser", int'(iu.lesser), 1);
        chk("lit_2v5_out_valid", int'(iu.out_valid), 1);
        chk("lit_2v5_cnt_lt", int'(iu.cnt_lt), 1);
        step(7, 7, 1'b1, 1'b0);
        chk("lit_7v7_equal", int'(iu.equal), 1);
        step(6, 0, 1'b1, 1'b0);
        chk("lit_6v0_greater", int'(iu.greater), 1);

        // Hold: invalid cycles with operands toggling
        step(0, 7, 1'b0, 1'b0);
        step(7, 0, 1'b0, 1'b0);
        step(1, 6, 1'b0, 1'b0);
        chk("lit_hold_greater", int'(iu.greater), 1);
        chk("lit_hold_lesser", int'(iu.lesser), 0);
        chk("lit_hold_out_valid", int'(iu.out_valid), 0);

        step(1, 3, 1'b1, 1'b1);
        chk("lit_clr_cnt_lt", int'(iu.cnt_lt), 0);
        chk("lit_clr_lesser", int'(iu.lesser), 1);

        for (int i = 0; i < 5; i++) step(4, 4, 1'b1, 1'b0);
        chk("lit_sat_c_cnt_eq", int'(ic.cnt_eq), 3);
        chk("lit_sat_u_cnt_eq", int'(iu.cnt_eq), 5);

        step(4, 3, 1'b1, 1'b0);
        chk("lit_signed_lesser", int'(i_s.lesser), 1);
        chk("lit_unsigned_greater", int'(iu.greater), 1);

        step(0, 0, 1'b0, 1'b1);
        for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << W); b++)
                step(a, b, 1'b1, 1'b0);
        chk("lit_exh_u_lt", int'(iu.cnt_lt), 28);
        chk("lit_exh_u_eq", int'(iu.cnt_eq), 8);
        chk("lit_exh_u_gt", int'(iu.cnt_gt), 28);
        chk("lit_exh_s_lt", int'(i_s.cnt_lt), 28);
        chk("lit_exh_s_gt", int'(i_s.cnt_gt), 28);
        chk("lit_exh_c_gt", int'(ic.cnt_gt), 3);

        // Asynchronous reset between edges, mid-stream
        step(5, 2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(3, 6, 1'b1, 1'b0);
        chk("lit_post_rst_cnt_lt", int'(iu.cnt_lt), 1);
        chk("lit_post_rst_lesser", int'(iu.lesser), 1);
        step(0, 0, 1'b0, 1'b0);
        @(negedge clk);
        run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
